// File: rtl/imem_load_controller_if.sv
// imem_load_controller_if: UART byte stream in, instruction memory write port and load status out
// Signals:
//   rx_valid, rx_data   one-cycle byte strobe and byte from the UART receiver
//   reload              one-cycle request to discard the image and await a new frame
//   mem_we, mem_addr,   instruction memory write port, one strobe per 16-bit word
//   mem_wdata
//   load_done, cpu_run  valid image present, CPU may execute
//   load_err            last frame aborted (bad checksum or timeout)
//   words_loaded        words written in the current or last frame
// Modports: master = the load controller, slave = the UART/memory/CPU side.
interface imem_load_controller_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              reload;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              load_done;
   logic              load_err;
   logic              cpu_run;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      input  rx_valid, rx_data, reload,
      output mem_we, mem_addr, mem_wdata, load_done, load_err, cpu_run, words_loaded
   );

   modport slave (
      output rx_valid, rx_data, reload,
      input  mem_we, mem_addr, mem_wdata, load_done, load_err, cpu_run, words_loaded
   );
endinterface

// File: rtl/imem_load_controller.sv
// imem_load_controller: frames UART bytes into checksummed 16-bit instruction memory writes and gates CPU run
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   bus (master) rx_valid/rx_data/reload in; mem_we/mem_addr/mem_wdata,
//                load_done/load_err/cpu_run/words_loaded out
// Frame: SYNC_BYTE, COUNT (0 = full depth), 2*COUNT data bytes high byte first, CHK = XOR of data bytes.
module imem_load_controller #(
   parameter int         ADDR_W         = 8,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter int         TO_W           = 20
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   imem_load_controller_if.master bus
);
   typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE, ERROR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   n_words;
   logic [ADDR_W:0]   words_q;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [7:0]        hi_q;
   logic [7:0]        chk_q;
   logic              we_q;
   logic [TO_W-1:0]   to_cnt;
   logic              accept;
   logic              in_frame;
   logic              timeout;
   logic              last_word;

   // reload has priority over a byte arriving in the same cycle
   always_comb begin
      accept    = bus.rx_valid & ~bus.reload;
      in_frame  = (state == COUNT) | (state == HI) | (state == LO) | (state == CHECK);
      timeout   = in_frame & ~bus.rx_valid & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
      last_word = (words_q + (ADDR_W+1)'(1)) == n_words;
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (bus.reload)
         state_nxt = IDLE;
      else if (timeout)
         state_nxt = ERROR;
      else if (bus.rx_valid)
         case (state)
            IDLE, ERROR: state_nxt = (bus.rx_data == SYNC_BYTE) ? COUNT : state;
            COUNT:       state_nxt = HI;
            HI:          state_nxt = LO;
            LO:          state_nxt = last_word ? CHECK : HI;
            CHECK:       state_nxt = (bus.rx_data == chk_q) ? DONE : ERROR;
            default:     state_nxt = state;
         endcase
   end

   // The word is registered on the LO byte and written the following cycle;
   // addr/words_loaded advance as that write retires.
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         n_words <= '0;
         words_q <= '0;
         addr    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         hi_q    <= '0;
         chk_q   <= '0;
         we_q    <= 1'b0;
         to_cnt  <= '0;
      end else begin
         we_q   <= 1'b0;
         to_cnt <= (in_frame && !bus.rx_valid && !bus.reload && !timeout) ? to_cnt + TO_W'(1) : '0;
         if (we_q) begin
            addr    <= addr + ADDR_W'(1);
            words_q <= words_q + (ADDR_W+1)'(1);
         end
         if (accept)
            case (state)
               COUNT: begin
                  n_words <= (bus.rx_data == 8'd0) ? (ADDR_W+1)'(2**ADDR_W) : (ADDR_W+1)'(bus.rx_data);
                  addr    <= '0;
                  chk_q   <= '0;
                  words_q <= '0;
               end
               HI: begin
                  hi_q  <= bus.rx_data;
                  chk_q <= chk_q ^ bus.rx_data;
               end
               LO: begin
                  we_q    <= 1'b1;
                  addr_q  <= addr;
                  wdata_q <= {hi_q, bus.rx_data};
                  chk_q   <= chk_q ^ bus.rx_data;
               end
               default: ;
            endcase
      end

   // Status flags come straight from the registered state, so they change
   // the cycle after the deciding byte.
   assign bus.mem_we       = we_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.load_done    = (state == DONE);
   assign bus.cpu_run      = (state == DONE);
   assign bus.load_err     = (state == ERROR);
   assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_imem_load_controller.sv
// tb_imem_load_controller: vector table, hand sequences and random frames against a frame-level model
module tb_imem_load_controller;
   localparam int ADDR_W = 8;
   localparam int TO_CYC = 100;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   imem_load_controller_if #(.ADDR_W(ADDR_W)) bus ();

   imem_load_controller #(
      .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO_CYC), .TO_W(7)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus)
   );

   always #5 CLK = ~CLK;

   int          tests = 0;
   int          fails = 0;
   int          max_gap = 0;
   logic [7:0]  tx_q[$];
   logic [23:0] wr_q[$];
   logic [23:0] exp_wr[$];

   always @(negedge CLK) if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic send();
      foreach (tx_q[i]) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = tx_q[i];
         @(posedge CLK); #1;
         bus.rx_valid = 1'b0;
         repeat ($urandom_range(max_gap, 0)) begin @(posedge CLK); #1; end
      end
      tx_q.delete();
   endtask

   task automatic do_reload();
      bus.reload = 1'b1;
      @(posedge CLK); #1;
      bus.reload = 1'b0;
      idle(1);
      wr_q.delete();
   endtask

   task automatic check_result(input string tag, input bit done, input bit err, input int words);
      logic [31:0] a;
      idle(3);
      check({tag, " nwrites"}, 32'(wr_q.size()), 32'(exp_wr.size()));
      foreach (exp_wr[i]) begin
         if (i < wr_q.size()) a = 32'(wr_q[i]);
         else a = 32'hFFFF_FFFF;
         check($sformatf("%s write%0d", tag, i), a, 32'(exp_wr[i]));
      end
      check({tag, " load_done"}, 32'(bus.load_done), 32'(done));
      check({tag, " cpu_run"}, 32'(bus.cpu_run), 32'(done));
      check({tag, " load_err"}, 32'(bus.load_err), 32'(err));
      check({tag, " words_loaded"}, 32'(bus.words_loaded), 32'(words));
      wr_q.delete();
      exp_wr.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
      check({tag, " load_done"}, 32'(bus.load_done), 32'd0);
      check({tag, " load_err"}, 32'(bus.load_err), 32'd0);
      check({tag, " cpu_run"}, 32'(bus.cpu_run), 32'd0);
      check({tag, " words_loaded"}, 32'(bus.words_loaded), 32'd0);
   endtask

   typedef struct {
      bit          reload_first;
      int          len;
      logic [63:0] bytes;
      int          nw;
      logic [23:0] w0;
      logic [23:0] w1;
      bit          done;
      bit          err;
      int          words;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b1, 7, 64'hA5_02_13_50_D3_00_90, 2, 24'h00_1350, 24'h01_D300, 1'b1, 1'b0, 2};
      vecs[1] = '{1'b1, 7, 64'hA5_02_13_50_D3_00_91, 2, 24'h00_1350, 24'h01_D300, 1'b0, 1'b1, 2};
      vecs[2] = '{1'b0, 5, 64'hA5_01_FF_FF_00,       1, 24'h00_FFFF, 24'h0,       1'b1, 1'b0, 1};
      vecs[3] = '{1'b0, 5, 64'hA5_01_11_22_33,       0, 24'h0,       24'h0,       1'b1, 1'b0, 1};
      vecs[4] = '{1'b1, 7, 64'h00_7F_A5_01_AB_CD_66, 1, 24'h00_ABCD, 24'h0,       1'b1, 1'b0, 1};
      vecs[5] = '{1'b1, 5, 64'hA5_01_A5_A5_00,       1, 24'h00_A5A5, 24'h0,       1'b1, 1'b0, 1};
      vecs[6] = '{1'b1, 7, 64'hA5_02_A5_01_02_03_A5, 2, 24'h00_A501, 24'h01_0203, 1'b1, 1'b0, 2};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.reload   = 1'b0;
      RST_N        = 1'b0;
      idle(2);
      check_zero("reset");
      @(negedge CLK) RST_N = 1'b1;
      idle(2);

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].reload_first) do_reload();
         for (int i = 0; i < vecs[v].len; i++) tx_q.push_back(vecs[v].bytes[8*(vecs[v].len-1-i) +: 8]);
         if (vecs[v].nw > 0) exp_wr.push_back(vecs[v].w0);
         if (vecs[v].nw > 1) exp_wr.push_back(vecs[v].w1);
         max_gap = 0;
         send();
         check_result($sformatf("vec%0d", v), vecs[v].done, vecs[v].err, vecs[v].words);
      end

      do_reload();
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'h00);
      for (int i = 0; i < 512; i++) tx_q.push_back(8'(i));
      tx_q.push_back(8'h00);
      for (int k = 0; k < 256; k++) exp_wr.push_back({8'(k), 8'(2*k), 8'(2*k+1)});
      max_gap = 0;
      send();
      check_result("full256", 1'b1, 1'b0, 256);

      do_reload();
      tx_q = '{8'hA5, 8'h03, 8'h12};
      send();
      idle(50);
      check("timeout early load_err", 32'(bus.load_err), 32'd0);
      idle(60);
      check("timeout load_err", 32'(bus.load_err), 32'd1);
      check("timeout cpu_run", 32'(bus.cpu_run), 32'd0);
      check("timeout nwrites", 32'(wr_q.size()), 32'd0);
      tx_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
      exp_wr.push_back(24'h00_1234);
      send();
      check_result("after_timeout", 1'b1, 1'b0, 1);

      bus.reload   = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h55;
      @(posedge CLK); #1;
      bus.reload   = 1'b0;
      bus.rx_valid = 1'b0;
      check("reload load_done", 32'(bus.load_done), 32'd0);
      check("reload cpu_run", 32'(bus.cpu_run), 32'd0);
      check("reload load_err", 32'(bus.load_err), 32'd0);
      check("reload words_held", 32'(bus.words_loaded), 32'd1);
      idle(3);
      check("reload nwrites", 32'(wr_q.size()), 32'd0);
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h01};
      exp_wr.push_back(24'h00_0001);
      send();
      check_result("reload_frame", 1'b1, 1'b0, 1);

      for (int f = 0; f < 30; f++) begin
         int         n;
         int         noise;
         bit         good;
         logic [7:0] x, hi, lo, c;
         do_reload();
         n     = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 1)) : int'($urandom_range(4, 1));
         noise = int'($urandom_range(3, 0));
         repeat (noise) begin
            x = 8'($urandom_range(255, 0));
            if (x == 8'hA5) x = 8'h5A;
            tx_q.push_back(x);
         end
         tx_q.push_back(8'hA5);
         tx_q.push_back(8'(n));
         c = 8'h00;
         for (int k = 0; k < n; k++) begin
            hi = 8'($urandom_range(255, 0));
            lo = 8'($urandom_range(255, 0));
            tx_q.push_back(hi);
            tx_q.push_back(lo);
            c = c ^ hi ^ lo;
            exp_wr.push_back({8'(k), hi, lo});
         end
         good = ($urandom_range(3, 0) != 0);
         tx_q.push_back(good ? c : c ^ 8'($urandom_range(255, 1)));
         max_gap = 2;
         send();
         check_result($sformatf("rand%0d", f), good, !good, n);
      end

      do_reload();
      tx_q = '{8'hA5, 8'h02, 8'h12, 8'h34};
      max_gap = 0;
      send();
      check("prereset mem_we", 32'(bus.mem_we), 32'd1);
      check("prereset mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      #1 RST_N = 1'b0;
      #1;
      check_zero("async_reset");
      @(negedge CLK) RST_N = 1'b1;
      idle(2);
      check_zero("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
